// File: rtl/if_fetch_unit.sv
// Instruction-fetch requester: req/ack memory read, IF/ID output register, PC freeze.
// Optional one-entry refetch buffer enabled by defining FETCH_REUSE_EN.
module if_fetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic              Flush,
  input  logic              StallIn,
  output logic              Freeze,
  output logic [DATA_W-1:0] Instruction,
  output logic              Valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          drop;

  logic              go;
  logic              acc;
  logic              tmo;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  assign go  = !StallIn && !Flush;
  assign acc = (state == WAIT) && mem_ack && !drop && !Flush;
  assign tmo = (state == WAIT) && !mem_ack
            && (cnt == CW'(MAX_WAIT));

`ifdef FETCH_REUSE_EN
  logic              buf_vld;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  assign hit      = buf_vld && (Address == buf_addr);
  assign hit_data = buf_data;

  // Memory is read-only, so a captured word never goes stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (acc) begin
      buf_vld  <= 1'b1;
      buf_addr <= mem_addr;
      buf_data <= mem_rdata;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    Freeze = 1'b1;
    if (Flush) begin
      Freeze = 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (go && hit) Freeze = 1'b0;
        WAIT:    if (acc && !StallIn) Freeze = 1'b0;
        HOLD:    if (!StallIn) Freeze = 1'b0;
        default: Freeze = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      Instruction <= '0;
      Valid       <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      Timeout     <= 1'b0;
      cnt         <= '0;
      drop        <= 1'b0;
    end else begin
      Valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            if (hit) begin
              Instruction <= hit_data;
              Valid       <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= Address;
              cnt      <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            drop    <= 1'b0;
            state   <= IDLE;
            if (acc) begin
              Instruction <= mem_rdata;
              if (StallIn) state <= HOLD;
              else Valid <= 1'b1;
            end
          end else if (tmo) begin
            Timeout <= 1'b1;
            mem_req <= 1'b0;
            drop    <= 1'b0;
            state   <= IDLE;
          end else begin
            // Memory cannot abort: keep the request up, discard its data later.
            cnt <= cnt + CW'(1);
            if (Flush) drop <= 1'b1;
          end
        end
        HOLD: begin
          if (Flush) begin
            state <= IDLE;
          end else if (!StallIn) begin
            Valid <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed fetches, waits, stalls,
// flushes, timeout and optional buffered refetch.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic        Flush;
  logic        StallIn;
  logic        Freeze;
  logic [31:0] Instruction;
  logic        Valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        Timeout;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .Flush(Flush),
    .StallIn(StallIn),
    .Freeze(Freeze),
    .Instruction(Instruction),
    .Valid(Valid),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .Timeout(Timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every Valid pulse must match the oldest expected word.
  always @(posedge clk) begin
    #1;
    if (!reset && Valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL valid_unexpected: got %h want none", Instruction);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (Instruction !== e) begin
          bad++;
          $display("FAIL valid_data: got %h want %h", Instruction, e);
        end
      end
    end
  end

  // From IDLE with Address=a: issue, wait `waits` cycles, ack with d.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input int waits);
    #1 chk("idle_freeze", Freeze, 1);
    tick();
    chk("req_issue", mem_req, 1);
    chk("req_addr", mem_addr, a);
    for (int i = 0; i < waits; i++) begin
      #1 chk("wait_freeze", Freeze, 1);
      tick();
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, a);
    end
    mem_ack   = 1'b1;
    mem_rdata = d;
    exp_q.push_back(d);
    #1 chk("ack_freeze", Freeze, 0);
    tick();
    mem_ack = 1'b0;
    chk("ack_req_drop", mem_req, 0);
    chk("ack_valid", Valid, 1);
  endtask

  initial begin
    reset     = 1'b1;
    Address   = 32'h0;
    Flush     = 1'b0;
    StallIn   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", Valid, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_timeout", Timeout, 0);
    chk("rst_instr", Instruction, 0);

    // Back-to-back single-wait fetches.
    fetch(32'h0, 32'hE3A0_1001, 0);
    Address = 32'h4;
    fetch(32'h4, 32'hE281_1002, 0);
    Address = 32'h8;

    // Three wait states.
    fetch(32'h8, 32'h1111_0008, 3);
    chk("t2_timeout", Timeout, 0);

    // Same address again: buffered refetch or plain memory fetch.
`ifdef FETCH_REUSE_EN
    exp_q.push_back(32'h1111_0008);
    #1 chk("reuse_freeze", Freeze, 0);
    tick();
    chk("reuse_req", mem_req, 0);
    chk("reuse_valid", Valid, 1);
    chk("reuse_instr", Instruction, 32'h1111_0008);
`else
    fetch(32'h8, 32'h2222_0008, 1);
`endif
    Address = 32'hC;

    // Ack under stall, one HOLD cycle, then release.
    #1 chk("t3_idle_freeze", Freeze, 1);
    tick();
    chk("t3_addr", mem_addr, 32'hC);
    StallIn   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h3333_000C;
    #1 chk("t3_ack_freeze", Freeze, 1);
    tick();
    mem_ack = 1'b0;
    chk("t3_hold_instr", Instruction, 32'h3333_000C);
    chk("t3_hold_valid", Valid, 0);
    chk("t3_hold_req", mem_req, 0);
    #1 chk("t3_hold_freeze", Freeze, 1);
    tick();
    chk("t3_hold_instr2", Instruction, 32'h3333_000C);
    StallIn = 1'b0;
    exp_q.push_back(32'h3333_000C);
    #1 chk("t3_rel_freeze", Freeze, 0);
    tick();
    chk("t3_rel_valid", Valid, 1);
    Address = 32'h10;

    // Flush while waiting; late ack must be dropped.
    tick();
    chk("t4_addr", mem_addr, 32'h10);
    Flush = 1'b1;
    #1 chk("t4_flush_freeze", Freeze, 0);
    tick();
    chk("t4_req_held", mem_req, 1);
    chk("t4_addr_held", mem_addr, 32'h10);
    Flush   = 1'b0;
    Address = 32'h40;
    #1 chk("t4_post_freeze", Freeze, 1);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1 chk("t4_drop_freeze", Freeze, 1);
    tick();
    mem_ack = 1'b0;
    chk("t4_drop_valid", Valid, 0);
    chk("t4_drop_req", mem_req, 0);
    fetch(32'h40, 32'h4444_0040, 0);
    Address = 32'h80;

    // Timeout after MAX_WAIT, then retry of the same address.
    tick();
    chk("t5_addr", mem_addr, 32'h80);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_req_hold", mem_req, 1);
      chk("t5_no_timeout", Timeout, 0);
    end
    tick();
    chk("t5_timeout", Timeout, 1);
    chk("t5_req_drop", mem_req, 0);
    fetch(32'h80, 32'h5555_0080, 0);
    chk("t5_sticky", Timeout, 1);

    // Async reset clears sticky Timeout.
    Address = 32'h0;
    reset   = 1'b1;
    #1 chk("rst2_timeout", Timeout, 0);
    chk("rst2_valid", Valid, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch requester on the consumer side of the program-counter register.
- Takes the PC `Address` and runs a req/ack read to instruction memory, which may insert wait states.
- Registers the returned word into the IF/ID-facing outputs.
- Drives `Freeze` back to the PC register so the PC advances only when the current instruction has been accepted.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- MAX_WAIT, 15, cycles in WAIT without `mem_ack` before timeout-and-retry (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Address  input  ADDR_W  current PC value
- Flush  input  1  branch taken; discard the in-flight or held instruction
- StallIn  input  1  downstream hazard stall
- Freeze  output  1  combinational; 1 holds the PC register
- Instruction  output  DATA_W  registered fetched word
- Valid  output  1  registered; Instruction is a live instruction this cycle
- mem_req  output  1  registered read request
- mem_addr  output  ADDR_W  registered request address
- mem_ack  input  1  memory read complete; mem_rdata valid
- mem_rdata  input  DATA_W  read data
- Timeout  output  1  sticky; set on any request timeout

Behaviour:
- Reset (async, immediate) puts:
  - state in IDLE
  - Instruction=0, Valid=0, mem_req=0, mem_addr=0, Timeout=0
  - wait counter=0, drop flag=0
- States: IDLE, WAIT, HOLD.
- Definition: "PC advance" is the condition Freeze=0.
- IDLE:
  - If StallIn=0 and Flush=0: mem_req<=1, mem_addr<=Address, counter<=0, go WAIT.
  - Otherwise remain in IDLE, mem_req=0.
  - Freeze=1 unless Flush=1.
- WAIT:
  - mem_req and mem_addr are held stable until mem_ack.
  - Counter increments each cycle without ack.
  - On mem_ack with drop=0 and Flush=0:
    - Instruction<=mem_rdata, mem_req<=0.
    - If StallIn=0: Freeze=0 this cycle, go IDLE.
    - If StallIn=1: Freeze=1, go HOLD.
  - On mem_ack with drop=1 (no Flush): data discarded, drop<=0, mem_req<=0, go IDLE, Freeze=1.
  - On counter==MAX_WAIT without ack: Timeout<=1, mem_req<=0, drop<=0, go IDLE. The next cycle re-issues for the current Address.
- HOLD:
  - Instruction is held, Freeze=1.
  - When StallIn=0: Freeze=0, go IDLE.
- Valid <= 1 on any clock edge where PC advance occurred from a real delivery (WAIT-ack or HOLD release); otherwise Valid <= 0. Valid is therefore a one-cycle pulse aligned with the PC's new value.
- Flush (priority over StallIn and ack):
  - Freeze=0 that cycle so the PC loads the branch target.
  - Valid<=0.
  - In WAIT without ack: drop<=1, stay in WAIT; mem_req and mem_addr are unchanged because memory cannot abort.
  - In WAIT with ack same cycle: data discarded, go IDLE.
  - In HOLD: go IDLE, held word discarded.
  - In IDLE: no request issued that cycle.
- Back-to-back throughput: at most 1 instruction per 2 cycles (IDLE issue, then ack at earliest on the next cycle).
- mem_ack outside WAIT is ignored.

Optional Feature:
- Macro: FETCH_REUSE_EN
- Defined:
  - One-entry buffer {buf_vld, buf_addr, buf_data}, loaded on every accepted (non-dropped) ack.
  - In IDLE with StallIn=0, Flush=0, buf_vld=1 and Address==buf_addr: no memory request; Instruction<=buf_data, Freeze=0, Valid<=1 next edge.
  - buf_vld is cleared only by reset; instruction memory is read-only.
- Undefined: every fetch goes to memory; no buffer storage exists.

Test Plan:
1. Reset, Address=0x0, then memory acks 1 cycle after each req with 0xE3A01001, 0xE2811002 -> Freeze low exactly on ack cycles; Valid pulses carry those words in order; mem_addr=0x0 then 0x4.
2. Memory with 3 wait states, StallIn=0 -> mem_req high 4 cycles with mem_addr stable; Freeze high until the ack cycle; one Valid pulse; Timeout=0.
3. Ack arrives while StallIn=1, StallIn released 2 cycles later -> state HOLD; Instruction stable; Freeze=1 for 2 cycles, then 0 for 1 cycle; Valid pulses once.
4. Flush raised in WAIT, ack 2 cycles later, Address now 0x40 -> Freeze=0 on the flush cycle only; ack data not delivered (Valid stays 0); next mem_addr=0x40.
5. MAX_WAIT=15 with no ack -> after 15 waiting cycles Timeout=1 and mem_req drops; re-request to the same address; Timeout stays 1 until reset.
6. FETCH_REUSE_EN defined, Address held at 0x8 after a fetch of 0x8 -> second fetch completes with mem_req=0 and a Valid pulse carrying the buffered word.
